// File: rtl/audio_dac_pkg.sv
// Shared constants and helpers for the audio DAC modulator.
// Mode encodings and frame length derivation.
package audio_dac_pkg;

   localparam logic MODE_PWM = 1'b0;
   localparam logic MODE_SD  = 1'b1;

   function automatic int frame_len(input int width);
      return 1 << width;
   endfunction

endpackage

// File: rtl/audio_dac_if.sv
// Sample handshake bundle between a sample source and the modulator.
// Channel k occupies sample_in[k*WIDTH +: WIDTH].
interface audio_dac_if #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 1
);

   logic [CHANNELS*WIDTH-1:0] sample_in;
   logic                      sample_valid;
   logic                      sample_ready;

   modport master (
      output sample_in,
      output sample_valid,
      input  sample_ready
   );

   modport slave (
      input  sample_in,
      input  sample_valid,
      output sample_ready
   );

endinterface

// File: rtl/audio_dac_mod_chan.sv
// One modulator channel: active sample, sigma-delta accumulator
// and registered 1-bit output.
module dac_chan_mod
   import audio_dac_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_in,
   input  logic             sys_rst,
   input  logic             load,
   input  logic             clr,
   input  logic             mode,
   input  logic [WIDTH-1:0] cnt,
   input  logic [WIDTH-1:0] hold,
   output logic             dac
);

   logic [WIDTH-1:0] active;
   logic [WIDTH-1:0] acc;
   logic [WIDTH:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, active};

   always_ff @(posedge clk_in) begin
      if (sys_rst) begin
         active <= '0;
         acc    <= '0;
         dac    <= 1'b0;
      end else begin
         if (load)
            active <= hold;
         // accumulator holds its value while in PWM mode
         if (clr)
            acc <= '0;
         else if (mode == MODE_SD)
            acc <= sum[WIDTH-1:0];
         if (mode == MODE_SD)
            dac <= sum[WIDTH];
         else
            dac <= (cnt < active);
      end
   end

endmodule

// File: rtl/audio_dac_mod.sv
// Multi-channel PWM / sigma-delta audio DAC modulator with a
// double-buffered sample path and underrun reporting.
module audio_dac_mod
   import audio_dac_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 1
) (
   input  logic                clk_in,
   input  logic                sys_rst,
   input  logic                mode_sd,
   audio_dac_if.slave          smp,
   output logic [CHANNELS-1:0] dac_out,
   output logic                frame_strobe,
   output logic                underrun
);

   localparam int FRAME = frame_len(WIDTH);
   localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(FRAME - 1);

   logic [WIDTH-1:0]          cnt;
   logic [CHANNELS*WIDTH-1:0] hold;
   logic                      hold_full;
   logic                      mode_q;
   logic                      frame_end;
   logic                      accept;
   logic                      load;
   logic                      clr;

   assign frame_end        = (cnt == CNT_MAX);
   assign smp.sample_ready = ~hold_full & ~sys_rst;
   assign accept           = smp.sample_valid & smp.sample_ready;
   assign load             = frame_end & hold_full;
   assign clr              = frame_end & (mode_sd != mode_q);

   always_ff @(posedge clk_in) begin
      if (sys_rst) begin
         cnt          <= '0;
         hold         <= '0;
         hold_full    <= 1'b0;
         mode_q       <= MODE_PWM;
         frame_strobe <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         cnt          <= cnt + 1'b1;
         frame_strobe <= frame_end;
         underrun     <= frame_end & ~hold_full;
         if (frame_end)
            mode_q <= mode_sd;
         // a sample taken on the frame-end cycle waits a full frame
         if (accept) begin
            hold      <= smp.sample_in;
            hold_full <= 1'b1;
         end else if (load) begin
            hold_full <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
      dac_chan_mod #(
         .WIDTH(WIDTH)
      ) u_chan (
         .clk_in (clk_in),
         .sys_rst(sys_rst),
         .load   (load),
         .clr    (clr),
         .mode   (mode_q),
         .cnt    (cnt),
         .hold   (hold[k*WIDTH +: WIDTH]),
         .dac    (dac_out[k])
      );
   end

endmodule

// File: tb/tb_audio_dac_mod.sv
// Bench for audio_dac_mod: an 8-bit mono and a 4-bit three-channel
// instance checked against a frame-level model every cycle.
module tb_audio_dac_mod;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       a_mode = 1'b0;
   logic       b_mode = 1'b0;
   logic [0:0] a_dac;
   logic [2:0] b_dac;
   logic       a_fs, a_ur, b_fs, b_ur;

   audio_dac_if #(.WIDTH(8), .CHANNELS(1)) a_if ();
   audio_dac_if #(.WIDTH(4), .CHANNELS(3)) b_if ();

   audio_dac_mod #(.WIDTH(8), .CHANNELS(1)) u_a (
      .clk_in      (clk),
      .sys_rst     (rst),
      .mode_sd     (a_mode),
      .smp         (a_if),
      .dac_out     (a_dac),
      .frame_strobe(a_fs),
      .underrun    (a_ur)
   );

   audio_dac_mod #(.WIDTH(4), .CHANNELS(3)) u_b (
      .clk_in      (clk),
      .sys_rst     (rst),
      .mode_sd     (b_mode),
      .smp         (b_if),
      .dac_out     (b_dac),
      .frame_strobe(b_fs),
      .underrun    (b_ur)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
      end
   endtask

   // Frame-level model: within a frame the mode and active sample are
   // fixed, so each output bit follows directly from its frame position.
   int NN[2] = '{256, 16};
   int NC[2] = '{1, 3};
   int m_p[2], m_full[2], m_mode[2];
   int m_hold[2][3], m_act[2][3];
   int e_dac[2][3];
   int e_fs[2], e_ur[2];
   int in_v[2], in_m[2], in_s[2][3];

   function automatic int exp_bit(input int sd, input int a, input int p, input int n);
      if (sd != 0)
         return ((p + 1) * a) / n - (p * a) / n;
      return (p < a) ? 1 : 0;
   endfunction

   task automatic model_step();
      int fe;
      int acc;
      in_v[0]    = int'(a_if.sample_valid);
      in_m[0]    = int'(a_mode);
      in_s[0][0] = int'(a_if.sample_in);
      in_v[1]    = int'(b_if.sample_valid);
      in_m[1]    = int'(b_mode);
      for (int k = 0; k < 3; k++)
         in_s[1][k] = int'(b_if.sample_in[k*4 +: 4]);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_p[i] = 0; m_full[i] = 0; m_mode[i] = 0;
            e_fs[i] = 0; e_ur[i] = 0;
            for (int k = 0; k < 3; k++) begin
               m_hold[i][k] = 0; m_act[i][k] = 0; e_dac[i][k] = 0;
            end
         end else begin
            for (int k = 0; k < NC[i]; k++)
               e_dac[i][k] = exp_bit(m_mode[i], m_act[i][k], m_p[i], NN[i]);
            fe  = (m_p[i] == NN[i] - 1) ? 1 : 0;
            acc = (in_v[i] != 0 && m_full[i] == 0) ? 1 : 0;
            e_fs[i] = fe;
            e_ur[i] = (fe != 0 && m_full[i] == 0) ? 1 : 0;
            if (fe != 0) begin
               m_mode[i] = in_m[i];
               if (m_full[i] != 0) begin
                  for (int k = 0; k < 3; k++) m_act[i][k] = m_hold[i][k];
                  m_full[i] = 0;
               end
            end
            if (acc != 0) begin
               for (int k = 0; k < 3; k++) m_hold[i][k] = in_s[i][k];
               m_full[i] = 1;
            end
            m_p[i] = (m_p[i] + 1) % NN[i];
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      chk("a_dac0", int'(a_dac[0]), e_dac[0][0]);
      chk("a_fs", int'(a_fs), e_fs[0]);
      chk("a_ur", int'(a_ur), e_ur[0]);
      chk("a_ready", int'(a_if.sample_ready), (m_full[0] == 0 && !rst) ? 1 : 0);
      for (int k = 0; k < 3; k++)
         chk($sformatf("b_dac%0d", k), int'(b_dac[k]), e_dac[1][k]);
      chk("b_fs", int'(b_fs), e_fs[1]);
      chk("b_ur", int'(b_ur), e_ur[1]);
      chk("b_ready", int'(b_if.sample_ready), (m_full[1] == 0 && !rst) ? 1 : 0);
   end

   int a_hi, a_adj, a_brk;
   int b_hi[3], b_adj[3];

   task automatic wait_fs(input int i);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (((i == 0) ? a_fs : b_fs) == 1'b0 && n < 600);
      if (((i == 0) ? a_fs : b_fs) == 1'b0)
         chk("fs_timeout", 0, 1);
   endtask

   task automatic push_a(input logic [7:0] d);
      int n;
      n = 0;
      a_if.sample_in = d;
      a_if.sample_valid = 1'b1;
      while (!a_if.sample_ready && n < 600) begin
         @(posedge clk); #1; n++;
      end
      if (!a_if.sample_ready) chk("push_a_timeout", 0, 1);
      @(posedge clk); #1;
      a_if.sample_valid = 1'b0;
   endtask

   task automatic push_b(input logic [11:0] d);
      int n;
      n = 0;
      b_if.sample_in = d;
      b_if.sample_valid = 1'b1;
      while (!b_if.sample_ready && n < 600) begin
         @(posedge clk); #1; n++;
      end
      if (!b_if.sample_ready) chk("push_b_timeout", 0, 1);
      @(posedge clk); #1;
      b_if.sample_valid = 1'b0;
   endtask

   // Call at a frame-strobe negedge; collects the next frame's bits.
   task automatic frame_a();
      int prev, seen0;
      prev = 0; seen0 = 0;
      a_hi = 0; a_adj = 0; a_brk = 0;
      repeat (256) begin
         @(negedge clk);
         if (a_dac[0]) begin
            a_hi++;
            if (prev != 0) a_adj++;
            if (seen0 != 0) a_brk++;
            prev = 1;
         end else begin
            seen0 = 1;
            prev = 0;
         end
      end
   endtask

   task automatic frame_b(input int sw);
      int prev[3];
      for (int k = 0; k < 3; k++) begin
         b_hi[k] = 0; b_adj[k] = 0; prev[k] = 0;
      end
      for (int j = 0; j < 16; j++) begin
         if (sw != 0 && j == 5) b_mode = 1'b1;
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (b_dac[k]) begin
               b_hi[k]++;
               if (prev[k] != 0) b_adj[k]++;
            end
            prev[k] = int'(b_dac[k]);
         end
      end
   endtask

   initial begin
      int n, acc;
      a_if.sample_valid = 1'b0; a_if.sample_in = '0;
      b_if.sample_valid = 1'b0; b_if.sample_in = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset asserted mid-frame
      repeat (100) @(negedge clk);
      @(posedge clk); #1 rst = 1'b1;
      for (int j = 0; j < 3; j++) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_dac", int'(a_dac[0]), 0);
         chk("rst_fs", int'(a_fs), 0);
         chk("rst_ur", int'(a_ur), 0);
         chk("rst_ready", int'(a_if.sample_ready), 0);
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", int'(a_if.sample_ready), 1);

      // PWM duty
      push_a(8'd64);
      wait_fs(0);
      frame_a();
      chk("pwm64_hi", a_hi, 64);
      chk("pwm64_contig", a_brk, 0);
      repeat (2) @(negedge clk);
      push_a(8'd0);
      wait_fs(0);
      frame_a();
      chk("pwm0_hi", a_hi, 0);
      repeat (2) @(negedge clk);
      push_a(8'd255);
      wait_fs(0);
      frame_a();
      chk("pwm255_hi", a_hi, 255);

      // underrun: no more samples offered
      for (int j = 0; j < 2; j++) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!a_fs && n < 600);
         chk("fs_spacing", n, 256);
         chk("ur_pulse", int'(a_ur), 1);
      end
      frame_a();
      chk("ur_repeat_hi", a_hi, 255);

      // sigma-delta density
      a_mode = 1'b1;
      push_a(8'd3);
      wait_fs(0);
      push_a(8'd3);
      frame_a();
      chk("sd3_hi", a_hi, 3);
      chk("sd3_adj", a_adj, 0);
      push_a(8'd128);
      wait_fs(0);
      frame_a();
      chk("sd128_hi", a_hi, 128);
      chk("sd128_adj", a_adj, 0);

      // back-pressure: valid held high
      a_mode = 1'b0;
      a_if.sample_in = 8'd100;
      a_if.sample_valid = 1'b1;
      wait_fs(0);
      wait_fs(0);
      acc = 0;
      for (int j = 0; j < 768; j++) begin
         if (a_if.sample_ready) acc++;
         @(negedge clk);
      end
      a_if.sample_valid = 1'b0;
      chk("bp_accepts", acc, 3);

      // sample offered on the frame-end cycle with holding empty
      repeat (254) @(negedge clk);
      @(posedge clk); #1;
      chk("sim_ready", int'(a_if.sample_ready), 1);
      a_if.sample_in = 8'd200;
      a_if.sample_valid = 1'b1;
      @(posedge clk); #1;
      a_if.sample_valid = 1'b0;
      @(negedge clk);
      chk("sim_fs", int'(a_fs), 1);
      chk("sim_ur", int'(a_ur), 1);
      chk("sim_ready_lo", int'(a_if.sample_ready), 0);
      frame_a();
      chk("sim_old_hi", a_hi, 100);
      chk("sim_no_ur", int'(a_ur), 0);
      frame_a();
      chk("sim_new_hi", a_hi, 200);

      // multi-channel, then a mid-frame mode switch
      push_b({4'd15, 4'd8, 4'd1});
      wait_fs(1);
      frame_b(0);
      chk("mc_hi2", b_hi[2], 15);
      chk("mc_hi1", b_hi[1], 8);
      chk("mc_hi0", b_hi[0], 1);
      chk("mc_adj1", b_adj[1], 7);
      frame_b(1);
      chk("sw_pwm_hi1", b_hi[1], 8);
      chk("sw_pwm_adj1", b_adj[1], 7);
      frame_b(0);
      chk("sw_sd_hi2", b_hi[2], 15);
      chk("sw_sd_hi1", b_hi[1], 8);
      chk("sw_sd_hi0", b_hi[0], 1);
      chk("sw_sd_adj1", b_adj[1], 0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/audio_dac_mod.md
Name: audio_dac_mod

Overview:
- Parametrised multi-channel audio DAC modulator. Converts WIDTH-bit unsigned samples into 1-bit drive signals for RC-filtered outputs.
- Runs on the carrier-rate clock. Sits downstream of cpfsk_mod (or any sample source) and replaces ad-hoc inline PWM logic.
- Adds a valid/ready sample handshake, a double-buffered sample path, a runtime-selectable PWM or first-order sigma-delta mode, and underrun reporting.

Parameters:
- WIDTH, 8, sample width in bits; the frame length is 2^WIDTH clocks.
- CHANNELS, 1, number of independent output channels, all sharing one frame counter.

Ports:
- clk_in  input  1  modulator clock (carrier clock)
- sys_rst  input  1  synchronous, active-high reset
- mode_sd  input  1  0 = PWM, 1 = first-order sigma-delta; sampled only at frame boundary
- sample_in  input  CHANNELS*WIDTH  packed samples; channel k occupies bits [k*WIDTH +: WIDTH]
- sample_valid  input  1  sample_in is valid
- sample_ready  output  1  holding register empty; transfer occurs when valid & ready
- dac_out  output  CHANNELS  registered 1-bit modulator outputs
- frame_strobe  output  1  one-cycle pulse on the last cycle of each frame
- underrun  output  1  one-cycle pulse when a frame ends with the holding register empty

Behaviour:
- Reset state (applies on any clk_in edge with sys_rst=1, including mid-frame):
  - counter = 0, all active samples = 0, holding register empty, all accumulators = 0, mode register = 0 (PWM).
  - dac_out = 0, frame_strobe = 0, underrun = 0.
  - sample_ready = 0 while sys_rst is high, then 1 on the first cycle after release.
- Counter:
  - WIDTH-bit, free-running, +1 per clock, wraps from 2^WIDTH-1 to 0.
  - The frame end is the cycle where counter == 2^WIDTH-1.
- Handshake:
  - sample_ready = ~hold_full & ~sys_rst.
  - On valid & ready, sample_in is captured into the holding register and hold_full is set.
  - While ready is low, sample_valid is ignored and the source must hold its data.
- Frame end:
  - If hold_full: holding copies to active, hold_full clears, and mode_sd is latched into the mode register.
  - If not hold_full: active is unchanged (last sample repeats), underrun pulses, and mode_sd is still latched.
  - frame_strobe, and underrun when applicable, are registered. They are high on the cycle after the counter == max cycle.
- Simultaneous events: a handshake occurring on the frame-end cycle with the holding register empty loads the holding register only. It does not bypass into active. underrun still pulses, and the new sample becomes active at the next frame end.
- PWM mode: dac_out[k] <= (counter < active[k]), registered.
  - Sample 0 gives constant 0.
  - Sample 2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH cycles.
- Sigma-delta mode:
  - Per channel: {carry, acc[k]} = acc[k] + active[k], computed in WIDTH+1 bits.
  - acc[k] <= low WIDTH bits; dac_out[k] <= carry.
  - Ones density = active/2^WIDTH exactly over each frame, independent of start phase.
  - Accumulators are cleared when the mode register changes value.
- Latency: a sample accepted in frame N becomes active at the end of frame N. It affects dac_out starting at counter == 0 of frame N+1, with one register stage (dac_out valid on the counter == 1 clock edge output).
- Channels are independent; all update on the same frame boundary.

Decomposition:
- Shared package audio_dac_pkg: MODE_PWM/MODE_SD constants and a helper that computes frame length from WIDTH.
- One natural sub-module: dac_chan_mod. It holds one channel's active register, accumulator and output flop. It is generated CHANNELS times.
- The counter, handshake, mode latch and strobes live in the top level.

Test Plan:
- Reset and defaults (WIDTH=8, CHANNELS=1): assert sys_rst for 3 cycles mid-frame -> dac_out=0, frame_strobe=0, underrun=0, sample_ready=0 during reset; ready=1 on the first cycle after release.
- PWM duty: push 8'd64, mode_sd=0 -> from the frame after transfer, exactly 64 high cycles per 256-cycle frame, contiguous from counter 0; push 8'd0 -> 0 highs; push 8'd255 -> 255 highs.
- Sigma-delta density: mode_sd=1, push 8'd3 every frame -> exactly 3 ones per 256-cycle frame, no two adjacent; push 8'd128 -> alternating 1/0 pattern.
- Underrun: push one sample then stop -> underrun pulses once per subsequent frame end, active sample repeats, and frame_strobe keeps 256-cycle spacing.
- Back-pressure and simultaneous events: hold valid high continuously -> exactly one accept per frame, ready low between accept and frame end. Offer a sample on the counter==255 cycle with holding empty -> underrun pulses, and the sample is active one frame later.
- Multi-channel (WIDTH=4, CHANNELS=3): samples {4'd15, 4'd8, 4'd1} -> per 16-cycle frame, highs = 15/8/1 on channels 2/1/0 respectively. Switch mode_sd mid-frame -> the change takes effect only at the next frame boundary.
